// File: rtl/combo_pkg.sv
// Shared defaults and types for the combo tracker and its timeout timer.
// Default timing is derived from the 50 MHz DE2-115 system clock.
package combo_pkg;

    localparam int unsigned CLK_HZ        = 50000000;
    localparam int unsigned TIMEOUT_SEC   = 3;

    localparam int          DEF_WIDTH          = 7;
    localparam int unsigned DEF_MAX_COMBO      = 99;
    localparam int unsigned DEF_HIT_INC        = 1;
    localparam int unsigned DEF_CLEAR_INC      = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = CLK_HZ * TIMEOUT_SEC;
    localparam int          DEF_TIMER_W        = 28;
    localparam int unsigned DEF_TIER_STEP      = 10;
    localparam int unsigned DEF_TIER_MAX       = 4;

    localparam int MULT_W = 3;

    // Winning event of a cycle after priority resolution.
    typedef enum logic [2:0] {
        EV_NONE,
        EV_NEW_GAME,
        EV_MISS,
        EV_CLEAR,
        EV_HIT,
        EV_TIMEOUT
    } combo_ev_e;

endpackage

// File: rtl/combo_timeout_timer.sv
// Idle timer for an active combo: counts enabled cycles and flags the cycle
// in which the count would wrap past TIMEOUT_CYCLES-1.
module combo_timeout_timer
    import combo_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int          TIMER_W        = DEF_TIMER_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               at_last;

    always_comb begin
        at_last = (timer_q == LAST);
        // A clear in the same cycle (any hit/miss/new game) suppresses expiry.
        expired = enable && !clear && at_last;
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (enable) begin
            timer_d = at_last ? '0 : timer_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/combo_tracker.sv
// Saturating combo counter with idle timeout, best-combo tracking, score
// multiplier tiers and a one-cycle combo-break pulse. All outputs registered.
module combo_tracker
    import combo_pkg::*;
#(
    parameter int          WIDTH          = DEF_WIDTH,
    parameter int unsigned MAX_COMBO      = DEF_MAX_COMBO,
    parameter int unsigned HIT_INC        = DEF_HIT_INC,
    parameter int unsigned CLEAR_INC      = DEF_CLEAR_INC,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int          TIMER_W        = DEF_TIMER_W,
    parameter int unsigned TIER_STEP      = DEF_TIER_STEP,
    parameter int unsigned TIER_MAX       = DEF_TIER_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_game,
    input  logic              miss,
    input  logic              non_full_clear_hit,
    input  logic              full_clear_hit,
    input  logic              pause,
    output logic [WIDTH-1:0]  combo_val,
    output logic [WIDTH-1:0]  best_combo,
    output logic [MULT_W-1:0] multiplier,
    output logic              combo_break,
    output logic [WIDTH-1:0]  broken_val
);

    // Sum is formed one bit wider than the combo so it cannot wrap before clamping.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input int unsigned      inc);
        logic [WIDTH:0] s;
        s = {1'b0, a} + (WIDTH+1)'(inc);
        if (s > (WIDTH+1)'(MAX_COMBO)) begin
            return WIDTH'(MAX_COMBO);
        end
        return s[WIDTH-1:0];
    endfunction

    // Threshold compare chain in place of a divide by TIER_STEP.
    function automatic logic [MULT_W-1:0] tier_of(input logic [WIDTH-1:0] c);
        logic [MULT_W-1:0] m;
        m = MULT_W'(1);
        for (int unsigned k = 1; k < TIER_MAX; k++) begin
            if (32'(c) >= k * TIER_STEP) begin
                m = MULT_W'(k + 1);
            end
        end
        return m;
    endfunction

    logic [WIDTH-1:0]  combo_q, combo_d;
    logic [WIDTH-1:0]  best_q, best_d;
    logic [WIDTH-1:0]  broken_q, broken_d;
    logic [MULT_W-1:0] mult_q, mult_d;
    logic              brk_q, brk_d;

    logic      tmr_clear, tmr_enable, tmr_expired;
    combo_ev_e ev;

    assign tmr_clear  = new_game | miss | full_clear_hit | non_full_clear_hit;
    assign tmr_enable = (combo_q != '0) && !pause;

    combo_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMER_W        (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    always_comb begin
        ev = EV_NONE;
        if (new_game) begin
            ev = EV_NEW_GAME;
        end else if (miss) begin
            ev = EV_MISS;
        end else if (full_clear_hit) begin
            ev = EV_CLEAR;
        end else if (non_full_clear_hit) begin
            ev = EV_HIT;
        end else if (tmr_expired) begin
            ev = EV_TIMEOUT;
        end
    end

    always_comb begin
        combo_d  = combo_q;
        broken_d = broken_q;
        brk_d    = 1'b0;
        case (ev)
            EV_NEW_GAME: combo_d = '0;
            EV_MISS, EV_TIMEOUT: begin
                // Timer only runs on a nonzero combo, so timeout always breaks.
                if (combo_q != '0) begin
                    combo_d  = '0;
                    broken_d = combo_q;
                    brk_d    = 1'b1;
                end
            end
            EV_CLEAR: combo_d = sat_add(combo_q, CLEAR_INC);
            EV_HIT:   combo_d = sat_add(combo_q, HIT_INC);
            default:  combo_d = combo_q;
        endcase
        best_d = (combo_d > best_q) ? combo_d : best_q;
        mult_d = tier_of(combo_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            combo_q  <= '0;
            best_q   <= '0;
            broken_q <= '0;
            mult_q   <= MULT_W'(1);
            brk_q    <= 1'b0;
        end else begin
            combo_q  <= combo_d;
            best_q   <= best_d;
            broken_q <= broken_d;
            mult_q   <= mult_d;
            brk_q    <= brk_d;
        end
    end

    assign combo_val   = combo_q;
    assign best_combo  = best_q;
    assign broken_val  = broken_q;
    assign multiplier  = mult_q;
    assign combo_break = brk_q;

endmodule

// File: tb/tb_combo_tracker.sv
// Directed bench for combo_tracker using a small configuration
// (WIDTH=4, MAX_COMBO=9, TIMEOUT_CYCLES=8, TIER_STEP=3, TIER_MAX=3).
`timescale 1ns/1ps
module tb_combo_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       new_game = 1'b0;
    logic       miss = 1'b0;
    logic       non_full_clear_hit = 1'b0;
    logic       full_clear_hit = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] combo_val, best_combo, broken_val;
    logic [2:0] multiplier;
    logic       combo_break;

    int n_vec = 0;
    int n_err = 0;

    combo_tracker #(
        .WIDTH(4), .MAX_COMBO(9), .HIT_INC(1), .CLEAR_INC(2),
        .TIMEOUT_CYCLES(8), .TIMER_W(4), .TIER_STEP(3), .TIER_MAX(3)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .new_game           (new_game),
        .miss               (miss),
        .non_full_clear_hit (non_full_clear_hit),
        .full_clear_hit     (full_clear_hit),
        .pause              (pause),
        .combo_val          (combo_val),
        .best_combo         (best_combo),
        .multiplier         (multiplier),
        .combo_break        (combo_break),
        .broken_val         (broken_val)
    );

    always #5 clk = ~clk;

    // Advance one active edge; outputs are then observed 1 ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse(input logic ng, input logic ms, input logic fc, input logic nfc);
        new_game = ng; miss = ms; full_clear_hit = fc; non_full_clear_hit = nfc;
        cyc();
        new_game = 0; miss = 0; full_clear_hit = 0; non_full_clear_hit = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({combo_val, best_combo, multiplier, combo_break, broken_val} !== {4'd0, 4'd0, 3'd1, 1'b0, 4'd0}) begin
            n_err++;
            $display("FAIL reset_state: got combo=%0d best=%0d mult=%0d brk=%0b broken=%0d, want 0 0 1 0 0",
                     combo_val, best_combo, multiplier, combo_break, broken_val);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_c [7] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd9, 4'd9, 4'd9};
        logic [2:0] exp_m [7] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 4) pulse(0, 0, 1, 0);
            else       pulse(0, 0, 0, 1);
            n_vec++;
            if (combo_val !== exp_c[i] || multiplier !== exp_m[i] || combo_break !== 1'b0) begin
                n_err++;
                $display("FAIL sat_step%0d: got combo=%0d mult=%0d brk=%0b, want combo=%0d mult=%0d brk=0",
                         i, combo_val, multiplier, combo_break, exp_c[i], exp_m[i]);
            end
        end
        n_vec++;
        if (best_combo !== 4'd9) begin
            n_err++;
            $display("FAIL sat_best: got %0d want 9", best_combo);
        end
    endtask

    task automatic test_miss_break();
        do_reset();
        pulse(0, 0, 1, 0); pulse(0, 0, 1, 0); pulse(0, 0, 0, 1);
        n_vec++;
        if (combo_val !== 4'd5) begin
            n_err++;
            $display("FAIL miss_setup: combo got %0d want 5", combo_val);
        end
        pulse(0, 1, 0, 0);
        n_vec++;
        if (combo_val !== 4'd0 || combo_break !== 1'b1 || broken_val !== 4'd5 ||
            multiplier !== 3'd1 || best_combo !== 4'd5) begin
            n_err++;
            $display("FAIL miss_break: got combo=%0d brk=%0b broken=%0d mult=%0d best=%0d, want 0 1 5 1 5",
                     combo_val, combo_break, broken_val, multiplier, best_combo);
        end
        cyc();
        n_vec++;
        if (combo_break !== 1'b0) begin
            n_err++;
            $display("FAIL miss_pulse_width: brk got %0b want 0", combo_break);
        end
        pulse(0, 1, 0, 0);
        n_vec++;
        if (combo_break !== 1'b0 || broken_val !== 4'd5 || combo_val !== 4'd0) begin
            n_err++;
            $display("FAIL miss_at_zero: got brk=%0b broken=%0d combo=%0d, want 0 5 0",
                     combo_break, broken_val, combo_val);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        pulse(0, 0, 1, 0); pulse(0, 0, 0, 1);
        idle(7);
        n_vec++;
        if (combo_val !== 4'd3 || combo_break !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_idle7: got combo=%0d brk=%0b, want 3 0", combo_val, combo_break);
        end
        cyc();
        n_vec++;
        if (combo_val !== 4'd0 || combo_break !== 1'b1 || broken_val !== 4'd3) begin
            n_err++;
            $display("FAIL timeout_break: got combo=%0d brk=%0b broken=%0d, want 0 1 3",
                     combo_val, combo_break, broken_val);
        end
        idle(12);
        n_vec++;
        if (combo_break !== 1'b0 || broken_val !== 4'd3) begin
            n_err++;
            $display("FAIL timeout_at_zero: got brk=%0b broken=%0d, want 0 3", combo_break, broken_val);
        end
    endtask

    task automatic test_pause();
        do_reset();
        pulse(0, 0, 1, 0); pulse(0, 0, 0, 1);
        idle(3);
        pause = 1'b1;
        idle(20);
        pause = 1'b0;
        idle(4);
        n_vec++;
        if (combo_val !== 4'd3 || combo_break !== 1'b0) begin
            n_err++;
            $display("FAIL pause_hold: got combo=%0d brk=%0b, want 3 0", combo_val, combo_break);
        end
        cyc();
        n_vec++;
        if (combo_val !== 4'd0 || combo_break !== 1'b1 || broken_val !== 4'd3) begin
            n_err++;
            $display("FAIL pause_break: got combo=%0d brk=%0b broken=%0d, want 0 1 3",
                     combo_val, combo_break, broken_val);
        end
    endtask

    task automatic test_expiry_hit();
        do_reset();
        pulse(0, 0, 1, 0); pulse(0, 0, 0, 1);
        idle(7);
        pulse(0, 0, 0, 1);
        n_vec++;
        if (combo_val !== 4'd4 || combo_break !== 1'b0) begin
            n_err++;
            $display("FAIL expiry_hit: got combo=%0d brk=%0b, want 4 0", combo_val, combo_break);
        end
        idle(7);
        n_vec++;
        if (combo_val !== 4'd4 || combo_break !== 1'b0) begin
            n_err++;
            $display("FAIL expiry_restart_hold: got combo=%0d brk=%0b, want 4 0", combo_val, combo_break);
        end
        cyc();
        n_vec++;
        if (combo_val !== 4'd0 || combo_break !== 1'b1 || broken_val !== 4'd4) begin
            n_err++;
            $display("FAIL expiry_restart_break: got combo=%0d brk=%0b broken=%0d, want 0 1 4",
                     combo_val, combo_break, broken_val);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        pulse(0, 0, 0, 1);
        pulse(0, 1, 1, 0);
        n_vec++;
        if (combo_val !== 4'd0 || combo_break !== 1'b1 || broken_val !== 4'd1) begin
            n_err++;
            $display("FAIL sim_miss_clear: got combo=%0d brk=%0b broken=%0d, want 0 1 1",
                     combo_val, combo_break, broken_val);
        end
        pulse(0, 0, 0, 1);
        pulse(0, 0, 1, 1);
        n_vec++;
        if (combo_val !== 4'd3 || multiplier !== 3'd2) begin
            n_err++;
            $display("FAIL sim_clear_hit: got combo=%0d mult=%0d, want 3 2", combo_val, multiplier);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_c [3] = '{4'd1, 4'd2, 4'd3};
        do_reset();
        non_full_clear_hit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_vec++;
            if (combo_val !== exp_c[i]) begin
                n_err++;
                $display("FAIL held_hit%0d: combo got %0d want %0d", i, combo_val, exp_c[i]);
            end
        end
        non_full_clear_hit = 1'b0;
    endtask

    task automatic test_new_game();
        do_reset();
        for (int i = 0; i < 5; i++) pulse(0, 0, 1, 0);
        pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        pulse(1, 0, 1, 0);
        n_vec++;
        if (combo_val !== 4'd0 || best_combo !== 4'd9 || combo_break !== 1'b0 ||
            multiplier !== 3'd1 || broken_val !== 4'd9) begin
            n_err++;
            $display("FAIL new_game: got combo=%0d best=%0d brk=%0b mult=%0d broken=%0d, want 0 9 0 1 9",
                     combo_val, best_combo, combo_break, multiplier, broken_val);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse(0, 0, 0, 1);
        pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0); pulse(0, 0, 1, 0); pulse(0, 0, 1, 0);
        idle(3);
        do_reset();
        n_vec++;
        if ({combo_val, best_combo, multiplier, combo_break, broken_val} !== {4'd0, 4'd0, 3'd1, 1'b0, 4'd0}) begin
            n_err++;
            $display("FAIL reset_mid: got combo=%0d best=%0d mult=%0d brk=%0b broken=%0d, want 0 0 1 0 0",
                     combo_val, best_combo, multiplier, combo_break, broken_val);
        end
        pulse(0, 0, 0, 1);
        idle(7);
        n_vec++;
        if (combo_val !== 4'd1 || combo_break !== 1'b0) begin
            n_err++;
            $display("FAIL reset_timer_clear: got combo=%0d brk=%0b, want 1 0", combo_val, combo_break);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_saturation();
        test_miss_break();
        test_timeout();
        test_pause();
        test_expiry_hit();
        test_simultaneous();
        test_back_to_back();
        test_new_game();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/combo_tracker.md
Name: combo_tracker

Overview:
- Parametrised successor to the game's combo counter: saturating combo count with configurable per-event increments, a hit-to-hit timeout that breaks idle combos, a best-combo register, a score-multiplier tier and a combo-break pulse.
- Sits between the mole hit/miss detection logic and the scoring/display logic on the DE2-115 (50 MHz) build.

Parameters:
- WIDTH, 7: bit width of combo_val, best_combo and broken_val; must hold MAX_COMBO.
- MAX_COMBO, 99: saturation ceiling.
- HIT_INC, 1: increment on non_full_clear_hit.
- CLEAR_INC, 2: increment on full_clear_hit.
- TIMEOUT_CYCLES, 150000000: idle cycles (3 s at 50 MHz) before an active combo breaks; must be >= 2.
- TIMER_W, 28: timeout counter width; must satisfy 2^TIMER_W > TIMEOUT_CYCLES.
- TIER_STEP, 10: combo points per multiplier tier; must be >= 1.
- TIER_MAX, 4: multiplier ceiling; must be <= 7.

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  synchronous active-high system reset; clears all state including best_combo
- new_game  in  1  clears combo, timer and multiplier; preserves best_combo
- miss  in  1  mole missed or wrong hole hit
- non_full_clear_hit  in  1  mole hit, board not cleared
- full_clear_hit  in  1  last mole on board hit
- pause  in  1  freezes timeout counter while high
- combo_val  out  WIDTH  current combo
- best_combo  out  WIDTH  highest combo_val since reset
- multiplier  out  3  score multiplier, 1..TIER_MAX
- combo_break  out  1  one-cycle pulse when a nonzero combo is lost
- broken_val  out  WIDTH  combo value at the most recent break; held until the next break

Behaviour:
- One clock (clk); reset synchronous, active-high; all outputs registered.
- Reset values: combo_val=0, best_combo=0, multiplier=1, combo_break=0, broken_val=0, timer=0.
- Event priority per cycle: reset > new_game > miss > full_clear_hit > non_full_clear_hit > timeout.
- Hit: next = combo_val + INC, computed at WIDTH+1 bits, clamped to MAX_COMBO. At MAX_COMBO, further hits hold MAX_COMBO and restart the timer.
- Miss with combo_val > 0: combo_val <= 0, broken_val <= combo_val, combo_break = 1 for one cycle. Miss with combo_val = 0: no pulse, broken_val unchanged.
- Timer:
  - Cleared on any hit, miss, new_game or reset.
  - Increments each cycle while combo_val > 0 and pause = 0; holds while pause = 1.
  - When timer = TIMEOUT_CYCLES-1 and it would increment: same action as a miss with combo_val > 0; timer <= 0.
  - Timeout never fires while combo_val = 0.
  - A hit in the expiry cycle wins: combo increments, no break, timer restarts.
- new_game: combo_val, timer <= 0; multiplier <= 1; no combo_break pulse; broken_val and best_combo unchanged.
- best_combo <= max(best_combo, next combo_val), updated in the same cycle as combo_val; never decreases except on reset.
- multiplier <= min(1 + floor(next combo_val / TIER_STEP), TIER_MAX), updated in the same cycle as combo_val. No divider: implement as a compare chain over tier thresholds k*TIER_STEP, k = 1..TIER_MAX-1.
- Latency: one cycle from an input event to all outputs.
- Inputs are single-cycle pulses from synchronous game logic. Held inputs count once per cycle.
- Reset asserted mid-combo or mid-timeout: everything returns to reset values next cycle; no combo_break pulse.

Decomposition:
- Shared package (combo_pkg):
  - defaults for MAX_COMBO, HIT_INC, CLEAR_INC, TIER_STEP, TIER_MAX;
  - CLK_HZ = 50000000 and the derived TIMEOUT_CYCLES;
  - localparam for the multiplier width (3).
- Sub-module combo_timeout_timer (ports clk, reset, clear, enable, expired), parametrised by TIMEOUT_CYCLES and TIMER_W.

Test Plan (WIDTH=4, MAX_COMBO=9, TIMEOUT_CYCLES=8, TIER_STEP=3, TIER_MAX=3):
- Saturation: reset; 4 full_clear_hit pulses then 3 non_full_clear_hit -> combo_val 2,4,6,8,9,9,9; multiplier 1,2,3,3,3,3,3; best_combo 9.
- Miss with break: combo=5, miss -> next cycle combo_val=0, combo_break=1 for exactly 1 cycle, broken_val=5, multiplier=1, best_combo=5. Miss again -> no pulse, broken_val stays 5.
- Timeout and pause:
  - combo=3, idle 7 cycles -> still 3; 8th idle cycle -> combo_val=0, combo_break=1, broken_val=3.
  - Repeat with pause high for 20 cycles mid-idle -> break delayed by exactly 20 cycles.
- Expiry vs hit: hit landing in the expiry cycle -> combo_val=4, no combo_break, timer restarts (break 8 idle cycles later).
- Simultaneous inputs: miss + full_clear_hit in one cycle -> combo_val=0. full_clear + non_full_clear with combo=1 -> combo_val=3.
- new_game vs reset: best_combo=9, new_game -> combo_val=0, best_combo=9, no pulse. reset with combo=6 mid-timeout -> all outputs at reset values, best_combo=0, no pulse.
